rram_wv_ctrl: RTL and testbench
===============================

RRAM_WV_CTRL -- requirements
Module: rram_wv_ctrl

Interface
- REQ-001: The block SHALL have parameter CELLS, default 16, number of behavioural RRAM cells.
- REQ-002: The block SHALL have parameter ADDR_W, default 4, cell address width.
- REQ-003: The block SHALL have parameter GAP_W, default 6, gap-state code width.
- REQ-004: The block SHALL have parameter GAP_MAX, default 48, full switching-layer gap code.
- REQ-005: The block SHALL have parameter W_W, default 4, filament-width code width.
- REQ-006: The block SHALL have parameter W_MAX, default 10, maximum filament-width code.
- REQ-007: The block SHALL have parameter SET_STEP, default 4, gap decrement per SET pulse.
- REQ-008: The block SHALL have parameter RESET_STEP, default 2, gap increment per RESET pulse.
- REQ-009: The block SHALL have parameter MAX_PULSES, default 15, pulse budget per write.
- REQ-010: The block SHALL have parameter SETTLE_CYC, default 2, settle cycles after each pulse (minimum 1).
- REQ-011: The block SHALL have parameter CRIT_GAP, default 4, gap code at or above which variation applies.
- REQ-012: The block SHALL have parameter SEED, default 16'hACE1, LFSR seed.
- REQ-013: The block SHALL have port clk, input, 1 bit, sole clock, rising edge.
- REQ-014: The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
- REQ-015: The block SHALL have ports req_valid (input, 1) and req_ready (output, 1), request handshake.
- REQ-016: The block SHALL have port req_op, input, 2 bits: 00 READ, 01 SET, 10 RESET, 11 treated as READ.
- REQ-017: The block SHALL have ports req_addr (input, ADDR_W) and req_target (input, GAP_W): RESET gap target, or SET width target in its low W_W bits.
- REQ-018: The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), response handshake.
- REQ-019: The block SHALL have ports rsp_gap (output, GAP_W), rsp_width (output, W_W), rsp_ok (output, 1) and rsp_pulses (output, 4): final cell state, pass flag and pulses used.

Function
- REQ-020: The FSM SHALL have states IDLE, READ, PULSE, SETTLE, VERIFY and DONE. req_ready SHALL be high only in IDLE.
- REQ-021: An accepted request SHALL latch op/addr/target. READ goes to READ and then to DONE, so rsp_valid rises 2 cycles after acceptance with rsp_ok=1 and rsp_pulses=0.
- REQ-022: SET/RESET SHALL go to PULSE. PULSE SHALL update the addressed cell, increment the pulse count and go to SETTLE. SETTLE SHALL last SETTLE_CYC cycles and then go to VERIFY.
- REQ-023: A SET pulse SHALL do: if gap>0, gap=max(gap-step,0); otherwise width=min(width+1,W_MAX).
- REQ-024: A RESET pulse SHALL set gap=min(gap+step,GAP_MAX) and leave width unchanged.
- REQ-025: In VERIFY, the block SHALL check pass: SET passes when gap==0 and width>=target[W_W-1:0]; RESET passes when gap>=min(target,GAP_MAX). On pass, go to DONE with rsp_ok=1. Else, if count==MAX_PULSES, go to DONE with rsp_ok=0. Else go to PULSE.
- REQ-026: In DONE, rsp_valid SHALL be high and the rsp_* outputs SHALL be held stable until rsp_ready. The transition to IDLE SHALL occur on the cycle after the handshake.
- REQ-027: A SET width target greater than W_MAX SHALL always end with rsp_ok=0 once the budget is exhausted.
- REQ-028: Cells other than the addressed cell SHALL never change.

Reset
- REQ-029: rst SHALL force state IDLE, req_ready=1, rsp_valid=0, rsp_gap=0, rsp_width=0, rsp_ok=0, rsp_pulses=0, every cell to gap=GAP_MAX and width=1, and the LFSR to SEED. This SHALL apply mid-operation as well, with the operation aborted and no response issued.

Configuration
- REQ-030: When RRAM_VARIATION_EN is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance once per PULSE. When gap>=CRIT_GAP before the pulse, the gap step SHALL be adjusted by lfsr[1:0]: 00 gives -1, 11 gives +1, otherwise 0, with a minimum step of 1.
- REQ-031: Without RRAM_VARIATION_EN, no LFSR SHALL exist and the steps SHALL be exactly SET_STEP/RESET_STEP.

Verification
- REQ-032: After reset, READ addr 5 -> rsp_gap=48, rsp_width=1, rsp_ok=1, rsp_pulses=0, rsp_valid 2 cycles after acceptance.
- REQ-033: SET addr 3, target 2 -> 12 gap pulses then 1 width pulse; rsp_gap=0, rsp_width=2, rsp_ok=1, rsp_pulses=13.
- REQ-034: Following that, RESET addr 3, target 20 -> rsp_gap=20, rsp_width=2, rsp_ok=1, rsp_pulses=10.
- REQ-035: From reset, SET addr 0, target 5 -> budget exhausted; rsp_gap=0, rsp_width=4, rsp_ok=0, rsp_pulses=15.
- REQ-036: Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and the data stay stable and req_ready stays 0; release -> IDLE on the next cycle.
- REQ-037: Assert rst during SETTLE of a SET on addr 7 -> no response; a later READ addr 7 returns gap=48, width=1.

Source files
------------

// File: rtl/rram_wv_if.sv
// Request/response handshake bundle for the RRAM write-verify controller.
interface rram_wv_if #(
    parameter int ADDR_W = 4,
    parameter int GAP_W  = 6,
    parameter int W_W    = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [GAP_W-1:0]  req_target;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [GAP_W-1:0]  rsp_gap;
    logic [W_W-1:0]    rsp_width;
    logic              rsp_ok;
    logic [3:0]        rsp_pulses;

    modport master (
        output req_valid, req_op, req_addr, req_target, rsp_ready,
        input  req_ready, rsp_valid, rsp_gap, rsp_width, rsp_ok, rsp_pulses
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_target, rsp_ready,
        output req_ready, rsp_valid, rsp_gap, rsp_width, rsp_ok, rsp_pulses
    );
endinterface

// File: rtl/rram_wv_ctrl.sv
// Write-verify controller over a behavioural RRAM array (gap/filament-width model).
// Define RRAM_VARIATION_EN to add LFSR-driven pulse-to-pulse step variation.
module rram_wv_ctrl #(
    parameter int          CELLS      = 16,
    parameter int          ADDR_W     = 4,
    parameter int          GAP_W      = 6,
    parameter int          GAP_MAX    = 48,
    parameter int          W_W        = 4,
    parameter int          W_MAX      = 10,
    parameter int          SET_STEP   = 4,
    parameter int          RESET_STEP = 2,
    parameter int          MAX_PULSES = 15,
    parameter int          SETTLE_CYC = 2,
    parameter int          CRIT_GAP   = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input logic       clk,
    input logic       rst,
    rram_wv_if.slave  bus
);

    localparam logic [GAP_W-1:0] GAP_FULL  = GAP_W'(GAP_MAX);
    localparam logic [W_W-1:0]   W_TOP     = W_W'(W_MAX);
    localparam logic [GAP_W:0]   SET_INC   = (GAP_W+1)'(SET_STEP);
    localparam logic [GAP_W:0]   RESET_INC = (GAP_W+1)'(RESET_STEP);
    localparam int               SETTLE_W  = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {IDLE, READ, PULSE, SETTLE, VERIFY, DONE} state_t;

    state_t               state;
    logic [1:0]           op_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [GAP_W-1:0]     target_q;
    logic [3:0]           pulse_cnt;
    logic [SETTLE_W-1:0]  settle_cnt;
    logic [GAP_W-1:0]     gap_mem   [CELLS];
    logic [W_W-1:0]       width_mem [CELLS];

    logic [GAP_W-1:0]     cur_gap, nxt_gap, reset_goal;
    logic [W_W-1:0]       cur_width, nxt_width;
    logic [GAP_W:0]       set_step, reset_step;
    logic                 is_set, pass;

    function automatic logic [GAP_W-1:0] gap_sub(input logic [GAP_W-1:0] g,
                                                 input logic [GAP_W:0]   step);
        logic signed [GAP_W+1:0] diff;
        diff = $signed({2'b00, g}) - $signed({1'b0, step});
        if (diff < 0) return '0;
        return diff[GAP_W-1:0];
    endfunction

    function automatic logic [GAP_W-1:0] gap_add(input logic [GAP_W-1:0] g,
                                                 input logic [GAP_W:0]   step);
        logic [GAP_W:0] sum;
        sum = {1'b0, g} + step;
        if (sum > {1'b0, GAP_FULL}) return GAP_FULL;
        return sum[GAP_W-1:0];
    endfunction

    function automatic logic [W_W-1:0] width_inc(input logic [W_W-1:0] w);
        if (w >= W_TOP) return W_TOP;
        return w + 1'b1;
    endfunction

`ifdef RRAM_VARIATION_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    function automatic logic [GAP_W:0] vary_step(input logic [GAP_W:0] s,
                                                 input logic [1:0]     r);
        case (r)
            2'b00:   return (s > (GAP_W+1)'(1)) ? s - 1'b1 : (GAP_W+1)'(1);
            2'b11:   return s + 1'b1;
            default: return s;
        endcase
    endfunction
`endif

    assign is_set     = (op_q == 2'b01);
    assign cur_gap    = gap_mem[addr_q];
    assign cur_width  = width_mem[addr_q];
    assign reset_goal = (target_q > GAP_FULL) ? GAP_FULL : target_q;

    always_comb begin
        set_step   = SET_INC;
        reset_step = RESET_INC;
`ifdef RRAM_VARIATION_EN
        if (cur_gap >= GAP_W'(CRIT_GAP)) begin
            set_step   = vary_step(SET_INC, lfsr[1:0]);
            reset_step = vary_step(RESET_INC, lfsr[1:0]);
        end
`endif
        nxt_gap   = cur_gap;
        nxt_width = cur_width;
        if (is_set) begin
            if (cur_gap != '0) nxt_gap = gap_sub(cur_gap, set_step);
            else               nxt_width = width_inc(cur_width);
        end else begin
            nxt_gap = gap_add(cur_gap, reset_step);
        end
        if (is_set) pass = (cur_gap == '0) && (cur_width >= target_q[W_W-1:0]);
        else        pass = (cur_gap >= reset_goal);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            target_q       <= '0;
            pulse_cnt      <= '0;
            settle_cnt     <= '0;
            bus.req_ready  <= 1'b1;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_gap    <= '0;
            bus.rsp_width  <= '0;
            bus.rsp_ok     <= 1'b0;
            bus.rsp_pulses <= '0;
            for (int i = 0; i < CELLS; i++) begin
                gap_mem[i]   <= GAP_FULL;
                width_mem[i] <= W_W'(1);
            end
`ifdef RRAM_VARIATION_EN
            lfsr <= SEED;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        op_q          <= bus.req_op;
                        addr_q        <= bus.req_addr;
                        target_q      <= bus.req_target;
                        pulse_cnt     <= '0;
                        bus.req_ready <= 1'b0;
                        state <= (bus.req_op == 2'b01 || bus.req_op == 2'b10) ? PULSE : READ;
                    end
                end
                READ: begin
                    bus.rsp_gap    <= cur_gap;
                    bus.rsp_width  <= cur_width;
                    bus.rsp_ok     <= 1'b1;
                    bus.rsp_pulses <= '0;
                    bus.rsp_valid  <= 1'b1;
                    state          <= DONE;
                end
                PULSE: begin
                    gap_mem[addr_q]   <= nxt_gap;
                    width_mem[addr_q] <= nxt_width;
                    pulse_cnt         <= pulse_cnt + 1'b1;
                    settle_cnt        <= SETTLE_W'(SETTLE_CYC - 1);
`ifdef RRAM_VARIATION_EN
                    lfsr <= {lfsr[14:0], lfsr_fb};
`endif
                    state <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= VERIFY;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                VERIFY: begin
                    // Give up only once the full pulse budget has been spent.
                    if (pass || pulse_cnt == 4'(MAX_PULSES)) begin
                        bus.rsp_gap    <= cur_gap;
                        bus.rsp_width  <= cur_width;
                        bus.rsp_ok     <= pass;
                        bus.rsp_pulses <= pulse_cnt;
                        bus.rsp_valid  <= 1'b1;
                        state          <= DONE;
                    end else begin
                        state <= PULSE;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rram_wv_ctrl.sv
// Scoreboard bench for rram_wv_ctrl: a reference cell model queues expected responses.
module tb_rram_wv_ctrl;

    typedef struct packed {
        logic [5:0] gap;
        logic [3:0] width;
        logic       ok;
        logic [3:0] pulses;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    int   m_gap   [16];
    int   m_width [16];

    rram_wv_if #(.ADDR_W(4), .GAP_W(6), .W_W(4)) bus ();

    rram_wv_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_gap[i]   = 48;
            m_width[i] = 1;
        end
        exp_q.delete();
    endtask

    // Reference model: pulse until pass or 15 pulses, pushing the expected response.
    task automatic model_push(input int op, input int addr, input int tgt);
        rsp_t e;
        int   n;
        bit   ok;
        n  = 0;
        ok = 1'b1;
        if (op == 1 || op == 2) begin
            ok = 1'b0;
            while (n < 15 && !ok) begin
                if (op == 1) begin
                    if (m_gap[addr] > 0) m_gap[addr] = (m_gap[addr] > 4) ? m_gap[addr] - 4 : 0;
                    else if (m_width[addr] < 10) m_width[addr]++;
                    ok = (m_gap[addr] == 0) && (m_width[addr] >= (tgt % 16));
                end else begin
                    m_gap[addr] = (m_gap[addr] + 2 > 48) ? 48 : m_gap[addr] + 2;
                    ok = m_gap[addr] >= ((tgt > 48) ? 48 : tgt);
                end
                n++;
            end
        end
        e.gap = 6'(m_gap[addr]);
        e.width = 4'(m_width[addr]);
        e.ok = ok;
        e.pulses = 4'(n);
        exp_q.push_back(e);
    endtask

    task automatic issue(input int op, input int addr, input int tgt);
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_ready_wait req_ready=%0b required 1 within 200 cycles", bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_op     = 2'(op);
        bus.req_addr   = 4'(addr);
        bus.req_target = 6'(tgt);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic collect(output rsp_t got, output bit timeout);
        timeout = 1'b1;
        got = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin timeout = 1'b0; break; end
        end
        if (!timeout) begin
            got = {bus.rsp_gap, bus.rsp_width, bus.rsp_ok, bus.rsp_pulses};
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1 bus.rsp_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_gap, bus.rsp_width, bus.rsp_ok, bus.rsp_pulses} !== 17'h10000) begin
            errors++;
            $display("FAIL reset_outputs got ready=%0b valid=%0b gap=%0d width=%0d ok=%0b pulses=%0d required 1 0 0 0 0 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_gap, bus.rsp_width, bus.rsp_ok, bus.rsp_pulses);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_read();
        rsp_t got, e;
        bit   to;
        model_push(0, 5, 0);
        issue(0, 5, 0);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_latency_early rsp_valid=%0b required 0", bus.rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL read_latency rsp_valid=%0b required 1", bus.rsp_valid);
        end
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e || got !== rsp_t'({6'd48, 4'd1, 1'b1, 4'd0})) begin
            errors++;
            $display("FAIL read_a5 got %p timeout=%0b required %p", got, to, e);
        end
    endtask

    task automatic test_set_write();
        rsp_t got, e;
        bit   to;
        model_push(1, 3, 2);
        issue(1, 3, 2);
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e || got !== rsp_t'({6'd0, 4'd2, 1'b1, 4'd13})) begin
            errors++;
            $display("FAIL set_a3 got %p timeout=%0b required %p", got, to, e);
        end
        model_push(0, 4, 0);
        issue(0, 4, 0);
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e) begin
            errors++;
            $display("FAIL neighbour_a4 got %p timeout=%0b required %p", got, to, e);
        end
    endtask

    task automatic test_reset_write();
        rsp_t got, e;
        bit   to;
        model_push(2, 3, 20);
        issue(2, 3, 20);
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e || got !== rsp_t'({6'd20, 4'd2, 1'b1, 4'd10})) begin
            errors++;
            $display("FAIL reset_a3 got %p timeout=%0b required %p", got, to, e);
        end
    endtask

    task automatic test_budget();
        rsp_t got, e;
        bit   to;
        do_reset();
        model_push(1, 0, 5);
        issue(1, 0, 5);
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e || got !== rsp_t'({6'd0, 4'd4, 1'b0, 4'd15})) begin
            errors++;
            $display("FAIL budget_a0 got %p timeout=%0b required %p", got, to, e);
        end
    endtask

    task automatic test_backpressure();
        rsp_t got, e, held;
        bit   seen = 1'b0;
        model_push(0, 3, 0);
        issue(0, 3, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin seen = 1'b1; break; end
        end
        e = exp_q.pop_front();
        held = {bus.rsp_gap, bus.rsp_width, bus.rsp_ok, bus.rsp_pulses};
        checks++;
        if (!seen || held !== e) begin
            errors++;
            $display("FAIL hold_first got %p valid_seen=%0b required %p", held, seen, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got = {bus.rsp_gap, bus.rsp_width, bus.rsp_ok, bus.rsp_pulses};
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 || got !== e) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%0b ready=%0b data=%p required 1 0 %p",
                         i, bus.rsp_valid, bus.req_ready, got, e);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_idle valid=%0b ready=%0b required 0 1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_abort();
        rsp_t got, e;
        bit   to;
        bit   spurious = 1'b0;
        issue(1, 7, 3);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) spurious = 1'b1;
        end
        checks++;
        if (spurious) begin
            errors++;
            $display("FAIL abort_quiet valid=%0b ready=%0b required 0 1", bus.rsp_valid, bus.req_ready);
        end
        model_push(0, 7, 0);
        issue(0, 7, 0);
        collect(got, to);
        e = exp_q.pop_front();
        checks++;
        if (to || got !== e || got !== rsp_t'({6'd48, 4'd1, 1'b1, 4'd0})) begin
            errors++;
            $display("FAIL abort_read_a7 got %p timeout=%0b required %p", got, to, e);
        end
    endtask

    task automatic test_back_to_back();
        rsp_t got, e;
        bit   to;
        int   op, addr, tgt;
        for (int n = 0; n < 10; n++) begin
            op   = $urandom_range(3, 0);
            addr = $urandom_range(15, 0);
            tgt  = (op == 1) ? $urandom_range(15, 0) : $urandom_range(63, 0);
            model_push(op, addr, tgt);
            issue(op, addr, tgt);
            collect(got, to);
            e = exp_q.pop_front();
            checks++;
            if (to || got !== e) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d addr=%0d tgt=%0d got %p timeout=%0b required %p",
                         n, op, addr, tgt, got, to, e);
            end
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_addr   = '0;
        bus.req_target = '0;
        bus.rsp_ready  = 1'b0;
        test_reset();
        test_read();
        test_set_write();
        test_reset_write();
        test_budget();
        test_backpressure();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
